// File: rtl/xdma_dw_pkg.sv
// -----------------------------------------------------------------------------
// xdma_dw_pkg
//   Shared helpers for the xDMA data-width converters (dw_packer,
//   dw_down_converter, dw_up_converter).
//   - dw_ratio(in_dw, out_dw): number of narrow lanes in one wide word.
//   - lane_mask(cnt, ratio)  : thermometer mask with lanes 0..cnt set,
//                              clipped to the number of real lanes.
//   - `CHECK_DW_PARAMS       : generate-scope guard that stops elaboration
//                              when the two widths cannot be converted.
// -----------------------------------------------------------------------------

`ifndef XDMA_DW_PKG_SV
`define XDMA_DW_PKG_SV

// Place at module scope. Elaboration fails unless out_dw is an exact
// multiple of in_dw and at least twice as wide.
`define CHECK_DW_PARAMS(in_dw, out_dw) \
  if ((((out_dw) % (in_dw)) != 0) || (((out_dw) / (in_dw)) < 2)) begin : g_bad_dw_params \
    $error("dw converter: OUTPUT_DW must be a multiple of INPUT_DW with a ratio of at least 2"); \
  end

package xdma_dw_pkg;

  // Widest lane mask lane_mask() can describe.
  localparam int unsigned MAX_RATIO = 64;

  // Number of narrow lanes that make up one wide word.
  function automatic int unsigned dw_ratio(input int unsigned in_dw,
                                           input int unsigned out_dw);
    return out_dw / in_dw;
  endfunction

  // Lanes 0..cnt set, lanes at or above ratio always clear.
  function automatic logic [MAX_RATIO-1:0] lane_mask(input int unsigned cnt,
                                                     input int unsigned ratio);
    logic [MAX_RATIO-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < MAX_RATIO; i++) begin
      if ((i <= cnt) && (i < ratio)) begin
        mask[i] = 1'b1;
      end else begin
        mask[i] = 1'b0;
      end
    end
    return mask;
  endfunction

endpackage

`endif

// File: rtl/dw_packer.sv
// -----------------------------------------------------------------------------
// dw_packer
//   Narrow-to-wide stream packer. Collects RATIO = OUTPUT_DW/INPUT_DW narrow
//   beats into one wide word, lane 0 (LSBs) holding the first beat. A beat
//   with last_i closes the word early; lanes that never received a beat read
//   as zero and are flagged clear in keep_o.
//
// Ports
//   clk_i    in   1          clock, rising edge
//   rst_i    in   1          synchronous, active-high reset
//   data_i   in   INPUT_DW   narrow beat
//   last_i   in   1          beat closes the current frame
//   valid_i  in   1          input beat valid
//   ready_o  out  1          beat accepted when valid_i & ready_o
//   data_o   out  OUTPUT_DW  packed wide word
//   keep_o   out  RATIO      bit k set = lane k holds a real beat
//   last_o   out  1          word is the final word of a frame
//   valid_o  out  1          output word valid
//   ready_i  in   1          word consumed when valid_o & ready_i
// -----------------------------------------------------------------------------

module dw_packer
  import xdma_dw_pkg::*;
#(
  parameter int unsigned INPUT_DW  = 64,
  parameter int unsigned OUTPUT_DW = 512,
  localparam int unsigned RATIO    = dw_ratio(INPUT_DW, OUTPUT_DW)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [INPUT_DW-1:0]  data_i,
  input  logic                 last_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [OUTPUT_DW-1:0] data_o,
  output logic [RATIO-1:0]     keep_o,
  output logic                 last_o,
  output logic                 valid_o,
  input  logic                 ready_i
);

  `CHECK_DW_PARAMS(INPUT_DW, OUTPUT_DW)

  if (RATIO > MAX_RATIO) begin : g_bad_ratio
    $error("dw_packer: RATIO exceeds the lane_mask() limit");
  end

  localparam int unsigned      CW        = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0]    LAST_LANE = CW'(RATIO - 1);

  // Only RATIO-1 lanes are buffered: the top lane is always the completing
  // beat itself and is taken straight from data_i.
  logic [INPUT_DW-1:0]  acc_r [RATIO-1];
  logic [CW-1:0]        cnt_r;

  logic [OUTPUT_DW-1:0] data_r;
  logic [RATIO-1:0]     keep_r;
  logic                 last_r;
  logic                 out_valid_r;

  logic                 ready_s;
  logic                 accept_s;
  logic                 complete_s;
  logic [RATIO-1:0]     mask_s;
  logic [OUTPUT_DW-1:0] word_s;

  // The output register can take a new word when it is empty or being drained.
  assign ready_s    = !out_valid_r | ready_i;
  assign accept_s   = valid_i & ready_s;
  assign complete_s = accept_s & (last_i | (cnt_r == LAST_LANE));

  // Lanes 0..cnt_r carry real data for the word being completed.
  assign mask_s = RATIO'(lane_mask(32'(cnt_r), RATIO));

  // Candidate wide word: current beat in lane cnt_r, buffered beats below it.
  // Lanes above cnt_r may hold data from an older frame; the mask zeroes them.
  for (genvar g = 0; g < RATIO; g++) begin : g_lane
    logic [INPUT_DW-1:0] lane_src;
    if (g < RATIO - 1) begin : g_buffered
      assign lane_src = (cnt_r == CW'(g)) ? data_i : acc_r[g];
    end else begin : g_top
      assign lane_src = data_i;
    end
    assign word_s[g*INPUT_DW +: INPUT_DW] = lane_src & {INPUT_DW{mask_s[g]}};
  end

  // Accumulator: store each non-completing beat into its lane.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < RATIO - 1; k++) begin
      if (rst_i) begin
        acc_r[k] <= '0;
      end else if (accept_s && !complete_s && (cnt_r == CW'(k))) begin
        acc_r[k] <= data_i;
      end else begin
        acc_r[k] <= acc_r[k];
      end
    end
  end

  // Lane counter: advances per accepted beat, restarts when a word completes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r <= '0;
    end else if (complete_s) begin
      cnt_r <= '0;
    end else if (accept_s) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Output register: load on completion (even while draining), else drain or hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_r      <= '0;
      keep_r      <= '0;
      last_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (complete_s) begin
      data_r      <= word_s;
      keep_r      <= mask_s;
      last_r      <= last_i;
      out_valid_r <= 1'b1;
    end else if (out_valid_r && ready_i) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign ready_o = ready_s;
  assign data_o  = data_r;
  assign keep_o  = keep_r;
  assign last_o  = last_r;
  assign valid_o = out_valid_r;

endmodule

// File: tb/tb_dw_packer.sv
// -----------------------------------------------------------------------------
// tb_dw_packer
//   Self-checking bench for dw_packer with INPUT_DW=64, OUTPUT_DW=256.
//   A queue-based reference model predicts ready_o/valid_o and the contents
//   of every output word; directed frames pin the model with literal values,
//   then randomized traffic with random back-pressure follows.
// -----------------------------------------------------------------------------

module tb_dw_packer;

  localparam int IDW = 64;
  localparam int ODW = 256;
  localparam int R   = ODW / IDW;

  logic           clk = 1'b0;
  logic           rst_i;
  logic [IDW-1:0] data_i;
  logic           last_i;
  logic           valid_i;
  logic           ready_o;
  logic [ODW-1:0] data_o;
  logic [R-1:0]   keep_o;
  logic           last_o;
  logic           valid_o;
  logic           ready_i;

  always #5 clk = ~clk;

  dw_packer #(.INPUT_DW(IDW), .OUTPUT_DW(ODW)) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .data_i (data_i),
    .last_i (last_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_o (data_o),
    .keep_o (keep_o),
    .last_o (last_o),
    .valid_o(valid_o),
    .ready_i(ready_i)
  );

  typedef struct {
    logic [ODW-1:0] d;
    logic [R-1:0]   k;
    logic           l;
  } word_t;

  word_t          exp_q[$];     // words produced and not yet consumed
  logic [IDW-1:0] frame_q[$];   // beats of the word being gathered
  int  n_cmp     = 0;
  int  n_bad     = 0;
  int  words_out = 0;
  int  cycles    = 0;
  bit  seen_rst  = 1'b0;
  bit  acc_flag  = 1'b0;

  task automatic chk(input string name, input logic [ODW-1:0] act, input logic [ODW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cycles++;

  // Reference model: at each falling edge check the DUT against the model,
  // then apply the inputs that the coming rising edge will sample.
  always @(negedge clk) begin : model
    word_t w;
    bit    rdy, cons, acc;
    if (seen_rst) begin
      rdy = (exp_q.size() == 0) || (ready_i == 1'b1);
      chk("ready_o", ODW'(ready_o), ODW'(rdy));
      chk("valid_o", ODW'(valid_o), ODW'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("data_o", data_o, exp_q[0].d);
        chk("keep_o", ODW'(keep_o), ODW'(exp_q[0].k));
        chk("last_o", ODW'(last_o), ODW'(exp_q[0].l));
      end
    end
    if (rst_i) begin
      exp_q.delete();
      frame_q.delete();
      seen_rst = 1'b1;
      acc_flag = 1'b0;
    end else begin
      cons = (exp_q.size() != 0) && (ready_i == 1'b1);
      acc  = (valid_i == 1'b1) && ((exp_q.size() == 0) || (ready_i == 1'b1));
      acc_flag = acc;
      if (cons) begin
        void'(exp_q.pop_front());
        words_out++;
      end
      if (acc) begin
        frame_q.push_back(data_i);
        if ((frame_q.size() == R) || (last_i == 1'b1)) begin
          w.d = '0;
          for (int i = 0; i < frame_q.size(); i++) w.d[i*IDW +: IDW] = frame_q[i];
          w.k = R'((1 << frame_q.size()) - 1);
          w.l = last_i;
          exp_q.push_back(w);
          frame_q.delete();
        end
      end
    end
  end

  // Present one beat and hold it until the model reports it accepted.
  task automatic send_beat(input logic [IDW-1:0] d, input logic l, input bit rnd);
    int cyc  = 0;
    bit done = 1'b0;
    data_i  = d;
    last_i  = l;
    valid_i = 1'b1;
    while (!done) begin
      if (rnd) ready_i = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      done = acc_flag;
      cyc++;
      if (!done && cyc > 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_beat: beat %h not accepted within 200 cycles", d);
        done = 1'b1;
      end
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  initial begin
    logic [ODW-1:0] lit;
    int             w0, c0;
    rst_i   = 1'b1;
    data_i  = '0;
    last_i  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", ODW'(valid_o), ODW'(1'b0));
    chk("rst_data",  data_o,        '0);
    chk("rst_keep",  ODW'(keep_o),  ODW'(4'h0));
    chk("rst_last",  ODW'(last_o),  ODW'(1'b0));
    rst_i = 1'b0;

    // 1: full four-beat frame
    send_beat(64'h11, 1'b0, 1'b0);
    send_beat(64'h22, 1'b0, 1'b0);
    send_beat(64'h33, 1'b0, 1'b0);
    chk("t1_not_early", ODW'(valid_o), ODW'(1'b0));
    send_beat(64'h44, 1'b1, 1'b0);
    lit = {64'h44, 64'h33, 64'h22, 64'h11};
    chk("t1_valid", ODW'(valid_o), ODW'(1'b1));
    chk("t1_data",  data_o,        lit);
    chk("t1_keep",  ODW'(keep_o),  ODW'(4'hF));
    chk("t1_last",  ODW'(last_o),  ODW'(1'b1));

    // 2: single-beat frame, loaded while the previous word drains
    send_beat(64'hAA, 1'b1, 1'b0);
    lit = {192'h0, 64'hAA};
    chk("t2_data", data_o,       lit);
    chk("t2_keep", ODW'(keep_o), ODW'(4'h1));
    chk("t2_last", ODW'(last_o), ODW'(1'b1));

    // 3: six-beat frame -> full word then two-lane word
    for (int i = 1; i <= 4; i++) send_beat(IDW'(64'h0101 * i), 1'b0, 1'b0);
    chk("t3_w1_keep", ODW'(keep_o), ODW'(4'hF));
    chk("t3_w1_last", ODW'(last_o), ODW'(1'b0));
    send_beat(64'h0505, 1'b0, 1'b0);
    send_beat(64'h0606, 1'b1, 1'b0);
    lit = {128'h0, 64'h0606, 64'h0505};
    chk("t3_w2_data", data_o,       lit);
    chk("t3_w2_keep", ODW'(keep_o), ODW'(4'h3));
    chk("t3_w2_last", ODW'(last_o), ODW'(1'b1));
    @(posedge clk); #1;

    // 4: output held full with ready_i low, next beat must wait
    ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) send_beat(IDW'(64'hB0 + i), 1'b0, 1'b0);
    lit = {64'hB4, 64'hB3, 64'hB2, 64'hB1};
    data_i  = 64'hB5;
    valid_i = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("t4_stall_ready", ODW'(ready_o), ODW'(1'b0));
      chk("t4_stall_data",  data_o,        lit);
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    send_beat(64'hB6, 1'b0, 1'b0);
    send_beat(64'hB7, 1'b0, 1'b0);
    send_beat(64'hB8, 1'b1, 1'b0);
    lit = {64'hB8, 64'hB7, 64'hB6, 64'hB5};
    chk("t4_next_data", data_o,       lit);
    chk("t4_next_keep", ODW'(keep_o), ODW'(4'hF));

    // 5: 64 back-to-back beats -> 16 words, no input stall
    @(posedge clk); #1;
    w0 = words_out;
    c0 = cycles;
    for (int i = 0; i < 64; i++) send_beat({$urandom, $urandom}, 1'b0, 1'b0);
    chk("t5_cycles", ODW'(cycles - c0), ODW'(64));
    repeat (3) @(posedge clk);
    #1;
    chk("t5_words", ODW'(words_out - w0), ODW'(16));

    // 6: reset mid-frame, stale lanes must not reappear
    send_beat(64'hC1, 1'b0, 1'b0);
    send_beat(64'hC2, 1'b0, 1'b0);
    rst_i = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_valid", ODW'(valid_o), ODW'(1'b0));
    chk("t6_rst_keep",  ODW'(keep_o),  ODW'(4'h0));
    rst_i = 1'b0;
    send_beat(64'h55, 1'b1, 1'b0);
    lit = {192'h0, 64'h55};
    chk("t6_data", data_o,       lit);
    chk("t6_keep", ODW'(keep_o), ODW'(4'h1));
    chk("t6_last", ODW'(last_o), ODW'(1'b1));

    // Randomized traffic with random idles, frame ends and back-pressure
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        ready_i = ($urandom_range(0, 1) != 0);
        @(posedge clk); #1;
      end
      send_beat({$urandom, $urandom}, ($urandom_range(0, 4) == 0), 1'b1);
    end
    ready_i = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
